// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: FFT size, default cyclic-prefix length,
// I/Q sample type and the cyclic-prefix read-FSM state encoding.
package ofdm_pkg;

  localparam int N_FFT          = 64;
  localparam int CP_LEN_DEFAULT = 16;
  localparam int DW_DEFAULT     = 8;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cp_pingpong_ram.sv
// Two-bank symbol buffer: one synchronous write port and one synchronous
// read port with a resettable output register. Bank select is the MSB of
// the internal address so each bank holds one full symbol.
module cp_pingpong_ram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2*DEPTH];

  // Storage write; array itself is not reset so it can map to block RAM.
  always_ff @(posedge clk)
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;

  // Read register only advances on rd_en, so the output holds between symbols.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion after the 64-point IFFT. Each completed symbol is
// replayed as its last CP_LEN samples followed by all N_FFT samples, using a
// ping-pong buffer so the next symbol can fill while the current one drains.
// Optional: define CP_INSERT_SYM_CNT_EN to add the sym_cnt output counter.
module cp_insert #(
  parameter  int N_FFT  = ofdm_pkg::N_FFT,
  parameter  int CP_LEN = ofdm_pkg::CP_LEN_DEFAULT,
  parameter  int DW     = ofdm_pkg::DW_DEFAULT,
  localparam int ADDR_W = $clog2(N_FFT)
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    din_index,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 din_vld,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 dout_vld,
  output logic                 dout_sop,
  output logic                 dout_eop,
  output logic                 din_err,
  output logic                 overflow
`ifdef CP_INSERT_SYM_CNT_EN
  ,
  output logic [15:0]          sym_cnt
`endif
);

  import ofdm_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_FFT - 1);
  // First read address of a symbol; wraps to 0 when there is no prefix.
  localparam logic [ADDR_W-1:0] CP_START = ADDR_W'(N_FFT - CP_LEN);
  localparam rd_state_t         FIRST_ST = (CP_LEN == 0) ? DATA : CP;

  logic [1:0]        full;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] exp_idx;
  logic              dropping;   // overflowed symbol being discarded
  logic              waiting;    // index error, ignoring until index 0
  logic              wr_acc, err_det, ovf_det, wr_set, rd_clr;
  rd_state_t         state;
  logic [ADDR_W-1:0] rd_cnt;
  logic              rd_en, sym_first;
  logic [2*DW-1:0]   rd_data;

  // Classify each input sample: accept, overflow, index error or ignore.
  always_comb begin
    wr_acc  = 1'b0;
    err_det = 1'b0;
    ovf_det = 1'b0;
    if (din_vld) begin
      if (dropping)
        wr_acc = (din_index == '0) && !full[wr_bank];
      else if (waiting && din_index != '0)
        wr_acc = 1'b0;
      else if (full[wr_bank])
        ovf_det = 1'b1;
      else if (din_index == exp_idx)
        wr_acc = 1'b1;
      else begin
        err_det = 1'b1;
        wr_acc  = (din_index == '0);
      end
    end
  end

  assign wr_set = wr_acc && (din_index == LAST_IDX);
  assign rd_clr = (state == DATA) && (rd_cnt == LAST_IDX);

  // Write-side sequencing: expected index, fill bank and error/drop flags.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      exp_idx  <= '0;
      dropping <= 1'b0;
      waiting  <= 1'b0;
      din_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      din_err  <= err_det;
      overflow <= ovf_det;
      if (ovf_det) begin
        dropping <= 1'b1;
        waiting  <= 1'b0;
      end
      if (wr_acc) begin
        dropping <= 1'b0;
        waiting  <= 1'b0;
        if (din_index == LAST_IDX) begin
          wr_bank <= ~wr_bank;
          exp_idx <= '0;
        end else begin
          exp_idx <= din_index + 1'b1;
        end
      end else if (err_det) begin
        waiting <= 1'b1;
        exp_idx <= '0;
      end
    end

  // Bank-full flags; set and clear never hit the same bank in one cycle.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) full <= '0;
    else begin
      if (rd_clr) full[rd_bank] <= 1'b0;
      if (wr_set) full[wr_bank] <= 1'b1;
    end

  // Read FSM: prefix tail, then whole symbol, chaining straight into a full bank.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (full[rd_bank]) begin
            state  <= FIRST_ST;
            rd_cnt <= CP_START;
          end
        CP: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_IDX) state <= DATA;
        end
        DATA: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_IDX) begin
            rd_bank <= ~rd_bank;
            if (full[~rd_bank]) begin
              state  <= FIRST_ST;
              rd_cnt <= CP_START;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end

  assign rd_en     = (state != IDLE);
  assign sym_first = (state == FIRST_ST) && (rd_cnt == CP_START);

  // Flags are delayed one cycle to line up with the registered RAM data.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= rd_en;
      dout_sop <= rd_en && sym_first;
      dout_eop <= rd_clr;
    end

  assign dout_re = rd_data[2*DW-1:DW];
  assign dout_im = rd_data[DW-1:0];

  cp_pingpong_ram #(.DEPTH(N_FFT), .WIDTH(2*DW)) u_ram (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_bank (wr_bank),
    .wr_addr (din_index),
    .wr_data ({din_re, din_im}),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

`ifdef CP_INSERT_SYM_CNT_EN
  // Symbols emitted; bumps the cycle after each end-of-symbol, wraps freely.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n)        sym_cnt <= '0;
    else if (dout_eop) sym_cnt <= sym_cnt + 1'b1;
`endif

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: default CP_LEN=16 instance plus a CP_LEN=0
// instance driven by the same input stream.
module tb_cp_insert;

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b1;
  logic [5:0]        din_index = '0;
  logic signed [7:0] din_re = '0, din_im = '0;
  logic              din_vld = 1'b0;

  logic signed [7:0] dout_re, dout_im, z_re, z_im;
  logic dout_vld, dout_sop, dout_eop, din_err, overflow;
  logic z_vld, z_sop, z_eop, z_err, z_ovf;
`ifdef CP_INSERT_SYM_CNT_EN
  logic [15:0] sym_cnt, z_sym_cnt;
`endif

  always #25 sys_clk = ~sys_clk;

  cp_insert dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .din_index(din_index), .din_re(din_re),
    .din_im(din_im), .din_vld(din_vld), .dout_re(dout_re), .dout_im(dout_im),
    .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .din_err(din_err), .overflow(overflow)
`ifdef CP_INSERT_SYM_CNT_EN
    , .sym_cnt(sym_cnt)
`endif
  );

  cp_insert #(.CP_LEN(0)) dut_z (
    .sys_clk(sys_clk), .rst_n(rst_n), .din_index(din_index), .din_re(din_re),
    .din_im(din_im), .din_vld(din_vld), .dout_re(z_re), .dout_im(z_im),
    .dout_vld(z_vld), .dout_sop(z_sop), .dout_eop(z_eop),
    .din_err(z_err), .overflow(z_ovf)
`ifdef CP_INSERT_SYM_CNT_EN
    , .sym_cnt(z_sym_cnt)
`endif
  );

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int n_err = 0, n_ovf = 0;
  int last_acc = 0;
  int q_re[$], q_im[$], q_sop[$], q_eop[$], q_cyc[$];
  int zq_re[$], zq_im[$], zq_sop[$], zq_eop[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge.
  always @(negedge sys_clk)
    if (rst_n) begin
      if (dout_vld) begin
        q_re.push_back(int'(dout_re)); q_im.push_back(int'(dout_im));
        q_sop.push_back(int'(dout_sop)); q_eop.push_back(int'(dout_eop));
        q_cyc.push_back(cyc);
      end
      if (z_vld) begin
        zq_re.push_back(int'(z_re)); zq_im.push_back(int'(z_im));
        zq_sop.push_back(int'(z_sop)); zq_eop.push_back(int'(z_eop));
      end
      if (din_err)  n_err++;
      if (overflow) n_ovf++;
    end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input int re, input int im);
    @(posedge sys_clk); #1;
    din_vld = 1'b1; din_index = 6'(idx); din_re = 8'(re); din_im = 8'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; din_vld = 1'b0; end
  endtask

  task automatic send_sym(input int off);
    for (int k = 0; k < 64; k++) drive(k, k + off, -k);
    last_acc = cyc + 1;
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    din_vld = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  int b, zb, e0, o0, cnt, zs;

  initial begin
    // Reset values
    #10 rst_n = 1'b0;
    #20;
    chk("rst_flags", int'({dout_vld, dout_sop, dout_eop, din_err, overflow}), 0);
    chk("rst_re", int'(dout_re), 0);
    chk("rst_im", int'(dout_im), 0);
    chk("rst_z_flags", int'({z_vld, z_sop, z_eop, z_err, z_ovf}), 0);
    #50 rst_n = 1'b1;

    // Single symbol, both CP_LEN builds
    do_reset();
    b = q_re.size(); zb = zq_re.size(); e0 = n_err; o0 = n_ovf;
    send_sym(0); idle(120);
    chk("t1_count", q_re.size() - b, 80);
    if (q_re.size() - b == 80) begin
      for (int i = 0; i < 80; i++) begin
        chk($sformatf("t1_re[%0d]", i), q_re[b+i], (i < 16) ? 48 + i : i - 16);
        chk($sformatf("t1_im[%0d]", i), q_im[b+i], (i < 16) ? -(48 + i) : -(i - 16));
      end
      chk("t1_latency", q_cyc[b] - last_acc, 2);
      chk("t1_contig", q_cyc[b+79] - q_cyc[b], 79);
      chk("t1_sop_first", q_sop[b], 1);
      chk("t1_eop_last", q_eop[b+79], 1);
      cnt = 0; for (int i = 0; i < 80; i++) cnt += q_sop[b+i] + q_eop[b+i];
      chk("t1_sop_eop_total", cnt, 2);
    end
    chk("t1_hold_re", int'(dout_re), 63);
    chk("t1_hold_vld", int'(dout_vld), 0);
    chk("t1_no_err", n_err - e0 + n_ovf - o0, 0);
    chk("t1z_count", zq_re.size() - zb, 64);
    if (zq_re.size() - zb == 64) begin
      chk("t1z_sop_first", zq_sop[zb], 1);
      chk("t1z_re_first", zq_re[zb], 0);
      chk("t1z_eop_last", zq_eop[zb+63], 1);
      chk("t1z_im5", zq_im[zb+5], -5);
      for (int i = 0; i < 64; i++) chk($sformatf("t1z_re[%0d]", i), zq_re[zb+i], i);
    end

    // Two symbols 80 cycles apart: gapless output
    do_reset();
    b = q_re.size();
    send_sym(0); idle(16); send_sym(64); idle(200);
    chk("t2_count", q_re.size() - b, 160);
    if (q_re.size() - b == 160) begin
      chk("t2_contig", q_cyc[b+159] - q_cyc[b], 159);
      chk("t2_sop0", q_sop[b], 1);
      chk("t2_sop80", q_sop[b+80], 1);
      chk("t2_eop79", q_eop[b+79], 1);
      chk("t2_eop159", q_eop[b+159], 1);
      chk("t2_re80", q_re[b+80], 112);
      chk("t2_re96", q_re[b+96], 64);
    end
`ifdef CP_INSERT_SYM_CNT_EN
    chk("t2_sym_cnt", int'(sym_cnt), 2);
`endif

    // Three symbols back-to-back: third dropped by overflow
    do_reset();
    b = q_re.size(); e0 = n_err; o0 = n_ovf;
    send_sym(0); send_sym(32); send_sym(64); idle(200);
    chk("t3_count", q_re.size() - b, 160);
    chk("t3_ovf", n_ovf - o0, 1);
    chk("t3_err", n_err - e0, 0);
    if (q_re.size() - b == 160) begin
      chk("t3_contig", q_cyc[b+159] - q_cyc[b], 159);
      chk("t3_re80", q_re[b+80], 80);
      chk("t3_re96", q_re[b+96], 32);
      chk("t3_sop80", q_sop[b+80], 1);
    end

    // Index error mid-symbol, then a clean symbol
    do_reset();
    b = q_re.size(); e0 = n_err; o0 = n_ovf;
    for (int k = 0; k <= 20; k++) drive(k, k, -k);
    drive(30, 30, -30); idle(100);
    chk("t4_err", n_err - e0, 1);
    chk("t4_no_out", q_re.size() - b, 0);
    send_sym(0); idle(120);
    chk("t4_count", q_re.size() - b, 80);
    chk("t4_err_after", n_err - e0, 1);
    chk("t4_ovf", n_ovf - o0, 0);
    if (q_re.size() - b == 80) chk("t4_re0", q_re[b], 48);

    // Reset in the middle of the output stream
    do_reset();
    b = q_re.size();
    send_sym(0); idle(1);
    for (int i = 0; i < 200 && (q_re.size() - b) < 40; i++) begin
      @(negedge sys_clk); #1;
    end
    chk("t5_reach40", int'((q_re.size() - b) >= 40), 1);
    rst_n = 1'b0; #1;
    chk("t5_rst_flags", int'({dout_vld, dout_sop, dout_eop, din_err, overflow}), 0);
    chk("t5_rst_re", int'(dout_re), 0);
    chk("t5_rst_im", int'(dout_im), 0);
    zs = zq_re.size();
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    idle(150);
    chk("t5_no_out", q_re.size() - b, 40);
    chk("t5z_no_out", zq_re.size() - zs, 0);
    chk("t5_vld", int'(dout_vld), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp_insert.md
Name: cp_insert

Overview:
Consumes the 64-point IFFT output stream (index, I/Q, valid) at 20 MHz and prepends a cyclic prefix. Each time-domain OFDM symbol is emitted as CP_LEN + N_FFT contiguous samples on the sys_clk domain. A two-bank ping-pong buffer lets one symbol fill while the previous one is read out. The block sits directly after the IFFT and feeds the TX framing/DAC path.

Parameters:
- N_FFT, 64: samples per symbol; power of 2; ADDR_W = log2(N_FFT) = 6.
- CP_LEN, 16: cyclic-prefix length; range 0..N_FFT-1.
- DW, 8: signed I/Q sample width.

Ports:
- sys_clk  in  1  20 MHz clock, only clock.
- rst_n  in  1  asynchronous active-low reset.
- din_index  in  ADDR_W  sample index within symbol, 0..N_FFT-1.
- din_re  in  DW  signed real sample.
- din_im  in  DW  signed imag sample.
- din_vld  in  1  sample valid; no backpressure toward the source.
- dout_re  out  DW  signed real output.
- dout_im  out  DW  signed imag output.
- dout_vld  out  1  output sample valid.
- dout_sop  out  1  high with the first CP sample of a symbol.
- dout_eop  out  1  high with the last data sample of a symbol.
- din_err  out  1  1-cycle pulse on an index sequence error.
- overflow  out  1  1-cycle pulse when a sample is dropped because no bank is free.

Behaviour:
- Reset values: all outputs 0; both banks empty; wr_bank=0, rd_bank=0; FSM in IDLE; expected index 0.
- Storage: 2 x N_FFT x (2*DW) RAM with synchronous read. Write address = din_index.
- Write side:
  - A sample is accepted only if din_vld, din_index == expected index, and full[wr_bank]=0.
  - Accepting din_index == N_FFT-1 sets full[wr_bank], toggles wr_bank and resets the expected index to 0.
- Index error: din_vld with din_index != expected pulses din_err and discards the partial symbol.
  - If that index is 0, it starts a new fill at 0.
  - Otherwise samples are ignored until index 0 arrives.
- Overflow: din_vld while full[wr_bank]=1 pulses overflow, drops the sample, and drops the rest of that symbol until index 0 arrives with a free bank. The index-error check is suppressed while dropping.
- Read FSM: IDLE -> CP -> DATA -> (CP or IDLE).
  - IDLE: when full[rd_bank] is seen, go to CP. If CP_LEN=0, go directly to DATA.
  - CP: read addresses N_FFT-CP_LEN .. N_FFT-1.
  - DATA: read addresses 0 .. N_FFT-1.
  - End of DATA: clear full[rd_bank] and toggle rd_bank. If the other bank is already full, enter CP with no idle cycle; otherwise go to IDLE.
- Latency: the first dout_vld asserts 2 sys_clk edges after the edge that accepts index N_FFT-1 (1 edge for the FSM, 1 for the RAM read register).
  - dout_vld then stays high for exactly CP_LEN+N_FFT consecutive cycles.
  - Back-to-back symbols produce a gapless dout_vld.
- Set and clear of full[] in the same cycle always target different banks; both take effect.
- Source contract: the source must not start a new symbol more often than once per CP_LEN+N_FFT cycles in steady state. Violations surface only as overflow pulses.
- dout_re/dout_im hold their last value when dout_vld=0.
- Reset asserted mid-symbol clears everything immediately. No partial symbol is emitted after release.

Optional Feature:
- Macro: CP_INSERT_SYM_CNT_EN.
- Defined: adds output sym_cnt [15:0]. It increments by 1 in the cycle after each dout_eop, wraps 0xFFFF->0, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ofdm_pkg holds:
  - N_FFT=64 and CP_LEN_DEFAULT=16;
  - the sample typedef (signed [DW-1:0] re/im struct);
  - the read-FSM state enum {IDLE, CP, DATA}.
- One natural sub-module: cp_pingpong_ram. It holds both banks, with a synchronous write port (bank, addr, data) and a synchronous read port (bank, addr) -> registered data. The FSM, bank flags and checks stay in cp_insert.

Test Plan:
- Single symbol, samples k=0..63 with re=k, im=-k -> 80 valid outputs: re=48..63 then 0..63; sop on the first, eop on the last; first valid 2 edges after the index-63 edge.
- Two symbols, second starting 80 cycles after the first -> 160 contiguous dout_vld cycles, no gap, two sop/eop pairs.
- Three symbols back-to-back at 64-cycle spacing -> third symbol dropped with overflow pulsed once; no din_err; exactly 2 symbols output.
- Index sequence 0..20 then 30 -> din_err pulse at 30, nothing output; a following full 0..63 outputs normally.
- Assert rst_n low at output sample 40 -> all outputs 0 immediately; after release with no input, dout_vld stays 0.
- CP_LEN=0 build, one symbol -> exactly 64 outputs 0..63, with sop and re=0 on the same first cycle.
